// File: rtl/ofs_fim_hssi_tx_axis_skid.sv
// rtl/ofs_fim_hssi_tx_axis_skid.sv - Registered 2-entry AXI-S skid buffer on the HSSI TX path; OFS_FIM_HSSI_TX_SKID_STATS_EN adds packet/error counters
module ofs_fim_hssi_tx_axis_skid #(
    parameter int DATA_W = 64,
    parameter int USER_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic [DATA_W/8-1:0]   s_tkeep,
    input  logic                  s_tlast,
    input  logic [USER_W-1:0]     s_tuser,

    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_W-1:0]     m_tdata,
    output logic [DATA_W/8-1:0]   m_tkeep,
    output logic                  m_tlast,
    output logic [USER_W-1:0]     m_tuser,

    output logic                  m_in_pkt
`ifdef OFS_FIM_HSSI_TX_SKID_STATS_EN
    ,
    output logic [31:0]           stat_pkt_cnt,
    output logic [15:0]           stat_err_cnt,
    input  logic                  stat_clr
`endif
);

    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state;

    // Second storage slot; only holds a beat while the buffer is FULL.
    logic [DATA_W-1:0]   skid_tdata;
    logic [KEEP_W-1:0]   skid_tkeep;
    logic                skid_tlast;
    logic [USER_W-1:0]   skid_tuser;

    logic                in_xfer;
    logic                out_xfer;

    // s_tready and m_tvalid are registers, so both handshakes see only flop outputs.
    assign in_xfer  = s_tvalid & s_tready;
    assign out_xfer = m_tvalid & m_tready;

    // Occupancy FSM: moves beats between input, main register (m_*) and skid register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            s_tready   <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tkeep    <= '0;
            m_tlast    <= 1'b0;
            m_tuser    <= '0;
            skid_tdata <= '0;
            skid_tkeep <= '0;
            skid_tlast <= 1'b0;
            skid_tuser <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    // Also the first edge after reset release: open the input.
                    s_tready <= 1'b1;
                    if (in_xfer) begin
                        m_tdata  <= s_tdata;
                        m_tkeep  <= s_tkeep;
                        m_tlast  <= s_tlast;
                        m_tuser  <= s_tuser;
                        m_tvalid <= 1'b1;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        m_tdata <= s_tdata;
                        m_tkeep <= s_tkeep;
                        m_tlast <= s_tlast;
                        m_tuser <= s_tuser;
                    end else if (in_xfer) begin
                        // Output stalled while a beat arrived: park it and close the input.
                        skid_tdata <= s_tdata;
                        skid_tkeep <= s_tkeep;
                        skid_tlast <= s_tlast;
                        skid_tuser <= s_tuser;
                        s_tready   <= 1'b0;
                        state      <= FULL;
                    end else if (out_xfer) begin
                        m_tvalid <= 1'b0;
                        state    <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        m_tdata  <= skid_tdata;
                        m_tkeep  <= skid_tkeep;
                        m_tlast  <= skid_tlast;
                        m_tuser  <= skid_tuser;
                        s_tready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    m_tvalid <= 1'b0;
                    s_tready <= 1'b1;
                    state    <= EMPTY;
                end
            endcase
        end
    end

    // Packet tracking of the output side: set by a non-last beat leaving, cleared by a last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_pkt <= 1'b0;
        end else if (out_xfer) begin
            m_in_pkt <= ~m_tlast;
        end
    end

`ifdef OFS_FIM_HSSI_TX_SKID_STATS_EN
    // Packet and errored-packet counters on output tlast beats; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkt_cnt <= '0;
            stat_err_cnt <= '0;
        end else if (stat_clr) begin
            stat_pkt_cnt <= '0;
            stat_err_cnt <= '0;
        end else if (out_xfer && m_tlast) begin
            stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            if (m_tuser[0]) begin
                stat_err_cnt <= stat_err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
